// File: rtl/rx_frame_ctrl.sv
// GMII receive framing controller: tracks preamble/SFD, counts frame bytes,
// classifies each frame and hands a status record downstream via valid/ready.
module rx_frame_ctrl #(
   parameter int MIN_FRAME_LEN = 64,
   parameter int MAX_FRAME_LEN = 1518,
   parameter int LEN_W         = 11
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             gmii_rx_valid_i,
   input  logic [7:0]       gmii_rx_data_i,
   input  logic             fcs_error_i,
   output logic             status_valid_o,
   input  logic             status_ready_i,
   output logic             status_good_o,
   output logic             status_fcs_err_o,
   output logic             status_runt_o,
   output logic             status_giant_o,
   output logic [LEN_W-1:0] status_len_o,
   output logic [31:0]      frames_good_cnt_o,
   output logic [31:0]      frames_bad_cnt_o,
   output logic [15:0]      status_drop_cnt_o,
   output logic [15:0]      preamble_err_cnt_o
);

   typedef enum logic [1:0] {S_IDLE, S_PREAMBLE, S_FRAME, S_DROP} state_e;

   localparam logic [7:0]       PRE_BYTE = 8'h55;
   localparam logic [7:0]       SFD_BYTE = 8'hD5;
   localparam logic [LEN_W-1:0] MIN_LEN  = LEN_W'(MIN_FRAME_LEN);
   localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(MAX_FRAME_LEN);
   localparam logic [LEN_W-1:0] LEN_SAT  = '1;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   state_e           state_q, state_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic             st_valid_q, st_valid_d;
   logic             st_good_q, st_good_d;
   logic             st_fcs_q, st_fcs_d;
   logic             st_runt_q, st_runt_d;
   logic             st_giant_q, st_giant_d;
   logic [LEN_W-1:0] st_len_q, st_len_d;
   logic [31:0]      good_cnt_q, good_cnt_d;
   logic [31:0]      bad_cnt_q, bad_cnt_d;
   logic [15:0]      drop_cnt_q, drop_cnt_d;
   logic [15:0]      pre_err_cnt_q, pre_err_cnt_d;

   logic capture;
   logic cap_runt, cap_giant, cap_good;

   assign cap_runt  = (len_q < MIN_LEN);
   assign cap_giant = (len_q > MAX_LEN);
   assign cap_good  = !(fcs_error_i || cap_runt || cap_giant);

   always_comb begin
      state_d       = state_q;
      len_d         = len_q;
      pre_err_cnt_d = pre_err_cnt_q;
      capture       = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (gmii_rx_valid_i) begin
               if (gmii_rx_data_i == PRE_BYTE) begin
                  state_d = S_PREAMBLE;
               end else begin
                  state_d       = S_DROP;
                  pre_err_cnt_d = sat_inc16(pre_err_cnt_q);
               end
            end
         end
         S_PREAMBLE: begin
            if (!gmii_rx_valid_i) begin
               state_d       = S_IDLE;
               pre_err_cnt_d = sat_inc16(pre_err_cnt_q);
            end else if (gmii_rx_data_i == SFD_BYTE) begin
               state_d = S_FRAME;
               len_d   = '0;
            end else if (gmii_rx_data_i != PRE_BYTE) begin
               state_d       = S_DROP;
               pre_err_cnt_d = sat_inc16(pre_err_cnt_q);
            end
         end
         S_FRAME: begin
            if (gmii_rx_valid_i) begin
               len_d = (len_q == LEN_SAT) ? len_q : len_q + 1'b1;
            end else begin
               state_d = S_IDLE;
               capture = 1'b1;
            end
         end
         S_DROP: begin
            if (!gmii_rx_valid_i) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // A capture arriving while the held status is stalled is discarded, not queued.
   always_comb begin
      st_valid_d = st_valid_q;
      st_good_d  = st_good_q;
      st_fcs_d   = st_fcs_q;
      st_runt_d  = st_runt_q;
      st_giant_d = st_giant_q;
      st_len_d   = st_len_q;
      good_cnt_d = good_cnt_q;
      bad_cnt_d  = bad_cnt_q;
      drop_cnt_d = drop_cnt_q;

      if (st_valid_q && status_ready_i) st_valid_d = 1'b0;

      if (capture) begin
         if (cap_good) good_cnt_d = good_cnt_q + 32'd1;
         else          bad_cnt_d  = bad_cnt_q + 32'd1;

         if (!st_valid_q || status_ready_i) begin
            st_valid_d = 1'b1;
            st_good_d  = cap_good;
            st_fcs_d   = fcs_error_i;
            st_runt_d  = cap_runt;
            st_giant_d = cap_giant;
            st_len_d   = len_q;
         end else begin
            drop_cnt_d = sat_inc16(drop_cnt_q);
         end
      end
   end

   // NOTE: state registers use non-blocking assignment only; all next-state math is in always_comb.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         len_q         <= '0;
         st_valid_q    <= 1'b0;
         st_good_q     <= 1'b0;
         st_fcs_q      <= 1'b0;
         st_runt_q     <= 1'b0;
         st_giant_q    <= 1'b0;
         st_len_q      <= '0;
         good_cnt_q    <= '0;
         bad_cnt_q     <= '0;
         drop_cnt_q    <= '0;
         pre_err_cnt_q <= '0;
      end else begin
         state_q       <= state_d;
         len_q         <= len_d;
         st_valid_q    <= st_valid_d;
         st_good_q     <= st_good_d;
         st_fcs_q      <= st_fcs_d;
         st_runt_q     <= st_runt_d;
         st_giant_q    <= st_giant_d;
         st_len_q      <= st_len_d;
         good_cnt_q    <= good_cnt_d;
         bad_cnt_q     <= bad_cnt_d;
         drop_cnt_q    <= drop_cnt_d;
         pre_err_cnt_q <= pre_err_cnt_d;
      end
   end

   assign status_valid_o     = st_valid_q;
   assign status_good_o      = st_good_q;
   assign status_fcs_err_o   = st_fcs_q;
   assign status_runt_o      = st_runt_q;
   assign status_giant_o     = st_giant_q;
   assign status_len_o       = st_len_q;
   assign frames_good_cnt_o  = good_cnt_q;
   assign frames_bad_cnt_o   = bad_cnt_q;
   assign status_drop_cnt_o  = drop_cnt_q;
   assign preamble_err_cnt_o = pre_err_cnt_q;

endmodule
